// File: rtl/shift_rows_stream.sv
// shift_rows_stream: registered ShiftRows / InvShiftRows stage for Rijndael
// states of NB columns, with a DEPTH-entry valid/ready output FIFO.
// Optional feature macro: SHIFT_ROWS_STREAM_BYPASS_EN adds in_bypass/out_bypass;
// a bypassed beat is buffered unshifted.
module shift_rows_stream #(
  parameter int NB    = 4,
  parameter int DEPTH = 2,
  localparam int W     = 32 * NB,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_inv,
`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
  input  logic             in_bypass,
  output logic             out_bypass,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_inv,
  output logic [OCC_W-1:0] occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
  localparam int EW = W + 2;
`else
  localparam int EW = W + 1;
`endif

  // Only the three Rijndael block widths have defined row offsets.
  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_stream: NB must be 4, 6 or 8");
    end
  endgenerate

  // Row offset: rows 2 and 3 shift one further for the 256-bit block.
  function automatic int row_shift(input int r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  // Byte (r,c) lives at bits [W-1-8*(4c+r) -: 8]; pick the source column per byte.
  function automatic logic [W-1:0] shift_state(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] res;
    int           src;
    res = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - row_shift(r) + NB) % NB : (c + row_shift(r)) % NB;
        res[W-1-8*(4*c+r) -: 8] = d[W-1-8*(4*src+r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             push;
  logic             pop;
  logic [W-1:0]     shifted_p0;
  logic [EW-1:0]    entry_p0;
  logic [EW-1:0]    buf_p1 [DEPTH];
  logic [EW-1:0]    head_p1;

  assign in_ready  = (occ != OCC_W'(DEPTH));
  assign out_valid = (occ != '0);
  assign occupancy = occ;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // ---- stage p0: combinational byte permutation of the incoming beat ----
  assign shifted_p0 = shift_state(in_data, in_inv);
`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
  assign entry_p0 = {(in_bypass ? in_data : shifted_p0), in_inv, in_bypass};
`else
  assign entry_p0 = {shifted_p0, in_inv};
`endif

  // ---- stage p1: circular buffer; output comes only from the head entry ----
  // Buffer storage is data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) buf_p1[wr_ptr] <= entry_p0;
  end

  // Pointer and occupancy bookkeeping; reset discards all buffered beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Outputs are forced to zero while empty so reset shows a clean zero state.
  assign head_p1  = buf_p1[rd_ptr];
`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
  assign out_data   = out_valid ? head_p1[EW-1 -: W] : '0;
  assign out_inv    = out_valid ? head_p1[1] : 1'b0;
  assign out_bypass = out_valid ? head_p1[0] : 1'b0;
`else
  assign out_data = out_valid ? head_p1[EW-1 -: W] : '0;
  assign out_inv  = out_valid ? head_p1[0] : 1'b0;
`endif

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream: NB=4 and NB=8 instances, DEPTH=2.
module tb_shift_rows_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // NB=4 instance
  logic         i4_valid, i4_ready, i4_inv, o4_valid, o4_ready, o4_inv;
  logic [127:0] i4_data, o4_data;
  logic [1:0]   occ4;
  // NB=8 instance
  logic         i8_valid, i8_ready, i8_inv, o8_valid, o8_ready, o8_inv;
  logic [255:0] i8_data, o8_data;
  logic [1:0]   occ8;
`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
  logic         i4_byp, o4_byp, i8_byp, o8_byp;
  assign i4_byp = 1'b0;
  assign i8_byp = 1'b0;
`endif

  shift_rows_stream #(.NB(4), .DEPTH(2)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(i4_valid), .in_ready(i4_ready), .in_data(i4_data), .in_inv(i4_inv),
`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
    .in_bypass(i4_byp), .out_bypass(o4_byp),
`endif
    .out_valid(o4_valid), .out_ready(o4_ready), .out_data(o4_data), .out_inv(o4_inv),
    .occupancy(occ4)
  );

  shift_rows_stream #(.NB(8), .DEPTH(2)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(i8_valid), .in_ready(i8_ready), .in_data(i8_data), .in_inv(i8_inv),
`ifdef SHIFT_ROWS_STREAM_BYPASS_EN
    .in_bypass(i8_byp), .out_bypass(o8_byp),
`endif
    .out_valid(o8_valid), .out_ready(o8_ready), .out_data(o8_data), .out_inv(o8_inv),
    .occupancy(occ8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] V_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] V_SR  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V_IDX = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] V_IDX_SR = 128'h00050a0f_04090e03_080d0207_0c01060b;
  localparam logic [255:0] V8_IN =
    256'h00010203_08090a0b_10111213_18191a1b_20212223_28292a2b_30313233_38393a3b;
  localparam logic [255:0] V8_SR =
    256'h00091a23_0811222b_10192a33_1821323b_20293a03_2831020b_30390a13_3801121b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for NB=4: each row as a 32-bit word, rotated by whole bytes.
  function automatic logic [127:0] model4(input logic [127:0] d, input logic inv);
    logic [127:0] res;
    logic [31:0]  row;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      row = {d[127-8*r -: 8], d[127-8*(4+r) -: 8], d[127-8*(8+r) -: 8], d[127-8*(12+r) -: 8]};
      if (r != 0)
        row = inv ? ((row >> (8*r)) | (row << (32-8*r))) : ((row << (8*r)) | (row >> (32-8*r)));
      for (int c = 0; c < 4; c++) res[127-8*(4*c+r) -: 8] = row[31-8*c -: 8];
    end
    return res;
  endfunction

  task automatic test_reset();
    #3;
    n_checks++; if (occ4 !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occ4); end
    n_checks++; if (o4_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", o4_valid); end
    n_checks++; if (i4_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", i4_ready); end
    n_checks++; if (o4_data !== 128'd0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", o4_data); end
    n_checks++; if (o4_inv !== 1'b0) begin n_fail++; $display("FAIL reset_out_inv got %b want 0", o4_inv); end
    n_checks++; if (o8_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8 got %b want 0", o8_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fwd4();
    i4_valid = 1'b1; i4_data = V_IN; i4_inv = 1'b0; o4_ready = 1'b1;
    n_checks++; if (o4_valid !== 1'b0) begin n_fail++; $display("FAIL fwd4_no_bypass got %b want 0", o4_valid); end
    tick();
    i4_valid = 1'b0; i4_data = '0;
    n_checks++; if (o4_valid !== 1'b1) begin n_fail++; $display("FAIL fwd4_valid got %b want 1", o4_valid); end
    n_checks++; if (o4_data !== V_SR) begin n_fail++; $display("FAIL fwd4_data got %h want %h", o4_data, V_SR); end
    n_checks++; if (o4_inv !== 1'b0) begin n_fail++; $display("FAIL fwd4_inv got %b want 0", o4_inv); end
    tick();
    n_checks++; if (o4_valid !== 1'b0) begin n_fail++; $display("FAIL fwd4_drain got %b want 0", o4_valid); end
  endtask

  task automatic test_inv4();
    i4_valid = 1'b1; i4_data = V_SR; i4_inv = 1'b1; o4_ready = 1'b1;
    tick();
    i4_valid = 1'b0; i4_inv = 1'b0;
    n_checks++; if (o4_data !== V_IN) begin n_fail++; $display("FAIL inv4_data got %h want %h", o4_data, V_IN); end
    n_checks++; if (o4_inv !== 1'b1) begin n_fail++; $display("FAIL inv4_inv got %b want 1", o4_inv); end
    tick();
  endtask

  task automatic test_nb8();
    i8_valid = 1'b1; i8_data = V8_IN; i8_inv = 1'b0; o8_ready = 1'b1;
    tick();
    i8_valid = 1'b0;
    n_checks++; if (o8_valid !== 1'b1) begin n_fail++; $display("FAIL nb8_valid got %b want 1", o8_valid); end
    n_checks++; if (o8_data !== V8_SR) begin n_fail++; $display("FAIL nb8_fwd got %h want %h", o8_data, V8_SR); end
    tick();
    i8_valid = 1'b1; i8_data = V8_SR; i8_inv = 1'b1;
    tick();
    i8_valid = 1'b0; i8_inv = 1'b0;
    n_checks++; if (o8_data !== V8_IN) begin n_fail++; $display("FAIL nb8_inv got %h want %h", o8_data, V8_IN); end
    n_checks++; if (o8_inv !== 1'b1) begin n_fail++; $display("FAIL nb8_inv_flag got %b want 1", o8_inv); end
    tick();
  endtask

  // Fill a 2-deep buffer under stall, then drain; third beat waits for space.
  task automatic test_backpressure();
    o4_ready = 1'b0;
    i4_valid = 1'b1; i4_data = V_IN; i4_inv = 1'b0;
    tick();
    i4_data = V_SR; i4_inv = 1'b1;
    tick();
    n_checks++; if (occ4 !== 2'd2) begin n_fail++; $display("FAIL bp_full_occ got %0d want 2", occ4); end
    n_checks++; if (i4_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", i4_ready); end
    i4_data = V_IDX; i4_inv = 1'b0;
    tick();
    n_checks++; if (occ4 !== 2'd2) begin n_fail++; $display("FAIL bp_hold_occ got %0d want 2", occ4); end
    n_checks++; if (o4_data !== V_SR) begin n_fail++; $display("FAIL bp_head got %h want %h", o4_data, V_SR); end
    o4_ready = 1'b1;
    tick();
    n_checks++; if (o4_data !== V_IN || o4_inv !== 1'b1) begin n_fail++; $display("FAIL bp_second got %h/%b want %h/1", o4_data, o4_inv, V_IN); end
    n_checks++; if (occ4 !== 2'd1 || i4_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_pop got occ %0d rdy %b want 1/1", occ4, i4_ready); end
    tick();
    i4_valid = 1'b0;
    n_checks++; if (o4_data !== V_IDX_SR || o4_inv !== 1'b0) begin n_fail++; $display("FAIL bp_third got %h want %h", o4_data, V_IDX_SR); end
    n_checks++; if (occ4 !== 2'd1) begin n_fail++; $display("FAIL bp_pushpop_occ got %0d want 1", occ4); end
    tick();
    n_checks++; if (o4_valid !== 1'b0 || occ4 !== 2'd0) begin n_fail++; $display("FAIL bp_empty got v %b occ %0d want 0/0", o4_valid, occ4); end
  endtask

  task automatic test_random();
    logic [128:0] q[$];
    logic [128:0] held;
    logic         held_vld;
    logic [128:0] exp;
    int           pushed, popped, cycles;
    pushed = 0; popped = 0; cycles = 0; held_vld = 1'b0; held = '0;
    while (popped < 1000 && cycles < 20000) begin
      i4_valid = (pushed < 1000) && ($urandom_range(0, 1) == 1);
      i4_data  = {$urandom, $urandom, $urandom, $urandom};
      i4_inv   = ($urandom_range(0, 1) == 1);
      o4_ready = ($urandom_range(0, 1) == 1);
      n_checks++;
      if (occ4 !== 2'(q.size())) begin n_fail++; $display("FAIL rnd_occ got %0d want %0d", occ4, q.size()); end
      if (held_vld) begin
        n_checks++;
        if ({o4_data, o4_inv} !== held) begin n_fail++; $display("FAIL rnd_stall_stable got %h want %h", {o4_data, o4_inv}, held); end
      end
      if (o4_valid && o4_ready) begin
        exp = (q.size() != 0) ? q.pop_front() : 129'd0;
        n_checks++;
        if ({o4_data, o4_inv} !== exp) begin n_fail++; $display("FAIL rnd_data got %h want %h", {o4_data, o4_inv}, exp); end
        popped++;
      end
      held_vld = o4_valid && !o4_ready;
      held     = {o4_data, o4_inv};
      if (i4_valid && i4_ready) begin
        q.push_back({model4(i4_data, i4_inv), i4_inv});
        pushed++;
      end
      tick();
      cycles++;
    end
    i4_valid = 1'b0; o4_ready = 1'b1;
    n_checks++;
    if (popped != 1000) begin n_fail++; $display("FAIL rnd_timeout got %0d beats want 1000", popped); end
    tick(); tick();
  endtask

  task automatic test_async_reset();
    o4_ready = 1'b0;
    i4_valid = 1'b1; i4_data = V_IN; i4_inv = 1'b0;
    tick(); tick();
    i4_valid = 1'b0;
    n_checks++; if (occ4 !== 2'd2) begin n_fail++; $display("FAIL ar_pre_occ got %0d want 2", occ4); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (o4_valid !== 1'b0) begin n_fail++; $display("FAIL ar_out_valid got %b want 0", o4_valid); end
    n_checks++; if (i4_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready got %b want 1", i4_ready); end
    n_checks++; if (occ4 !== 2'd0) begin n_fail++; $display("FAIL ar_occ got %0d want 0", occ4); end
    n_checks++; if (o4_data !== 128'd0) begin n_fail++; $display("FAIL ar_out_data got %h want 0", o4_data); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    i4_valid = 1'b1; i4_data = V_IDX; i4_inv = 1'b0; o4_ready = 1'b1;
    n_checks++; if (o4_valid !== 1'b0) begin n_fail++; $display("FAIL ar_post_empty got %b want 0", o4_valid); end
    tick();
    i4_valid = 1'b0;
    n_checks++; if (o4_valid !== 1'b1 || o4_data !== V_IDX_SR) begin n_fail++; $display("FAIL ar_first_beat got %b/%h want 1/%h", o4_valid, o4_data, V_IDX_SR); end
    tick();
  endtask

  initial begin
    i4_valid = 1'b0; i4_data = '0; i4_inv = 1'b0; o4_ready = 1'b0;
    i8_valid = 1'b0; i8_data = '0; i8_inv = 1'b0; o8_ready = 1'b0;
    test_reset();
    test_fwd4();
    test_inv4();
    test_nb8();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
